// File: rtl/mem_arbiter_pkg.sv
// Shared types for the three-client memory arbiter: FSM encoding and client indices.
// Pure definitions, no logic; no latency or backpressure of its own.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [1:0] cli_t;

  localparam cli_t CLI_CPU  = 2'd0;
  localparam cli_t CLI_GPU  = 2'd1;
  localparam cli_t CLI_SCAN = 2'd2;

  function automatic cli_t onehot_idx(input logic [2:0] oh);
    if (oh[1]) return CLI_GPU;
    if (oh[2]) return CLI_SCAN;
    return CLI_CPU;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Client request/ack ports plus the mem-side strobes of the arbiter.
// Requests are level-held until their one-cycle ack; the mem side is strobe/ack.
interface mem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic              cpu_read,  gpu_read,  scan_read;
  logic              cpu_write, gpu_write, scan_write;
  logic [ADDR_W-1:0] cpu_idx,   gpu_idx,   scan_idx;
  logic [DATA_W-1:0] cpu_wbyte, gpu_wbyte, scan_wbyte;
  logic              cpu_ack,   gpu_ack,   scan_ack;
  logic [DATA_W-1:0] rd_byte;

  logic              mem_read;
  logic [ADDR_W-1:0] mem_read_idx;
  logic [DATA_W-1:0] mem_read_byte;
  logic              mem_read_ack;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_write_idx;
  logic [DATA_W-1:0] mem_write_byte;

  // Environment view: drives client requests and plays the memory.
  modport master (
    output cpu_read, gpu_read, scan_read, cpu_write, gpu_write, scan_write,
    output cpu_idx, gpu_idx, scan_idx, cpu_wbyte, gpu_wbyte, scan_wbyte,
    input  cpu_ack, gpu_ack, scan_ack, rd_byte,
    input  mem_read, mem_read_idx, mem_write, mem_write_idx, mem_write_byte,
    output mem_read_byte, mem_read_ack
  );

  modport slave (
    input  cpu_read, gpu_read, scan_read, cpu_write, gpu_write, scan_write,
    input  cpu_idx, gpu_idx, scan_idx, cpu_wbyte, gpu_wbyte, scan_wbyte,
    output cpu_ack, gpu_ack, scan_ack, rd_byte,
    output mem_read, mem_read_idx, mem_write, mem_write_idx, mem_write_byte,
    input  mem_read_byte, mem_read_ack
  );
endinterface

// File: rtl/mem_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker: searches from the client after last.
// Zero latency; grant is one-hot, valid whenever any request is present.
module rr_pick3
  import mem_arb_pkg::*;
(
  input  logic [2:0] req,
  input  cli_t       last,
  output logic [2:0] grant,
  output logic       valid
);

  always_comb begin
    grant = 3'b000;
    case (last)
      CLI_CPU: begin
        if      (req[1]) grant = 3'b010;
        else if (req[2]) grant = 3'b100;
        else if (req[0]) grant = 3'b001;
      end
      CLI_GPU: begin
        if      (req[2]) grant = 3'b100;
        else if (req[0]) grant = 3'b001;
        else if (req[1]) grant = 3'b010;
      end
      default: begin
        if      (req[0]) grant = 3'b001;
        else if (req[1]) grant = 3'b010;
        else if (req[2]) grant = 3'b100;
      end
    endcase
    valid = |req;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises cpu/gpu/scan requests onto the single-port mem, round-robin, one at a time.
// Write: strobe+ack one cycle after sampling; read: ack one cycle after mem_read_ack; DONE gap follows each.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  logic [2:0]        rd_req, wr_req, req, grant;
  logic              valid;
  cli_t              win, gnt, last;
  state_t            state;
  logic [ADDR_W-1:0] sel_idx;
  logic [DATA_W-1:0] sel_wbyte;

  logic [2:0]        ack_q;
  logic [DATA_W-1:0] rd_byte_q, wr_byte_q;
  logic              mem_read_q, mem_write_q;
  logic [ADDR_W-1:0] rd_idx_q, wr_idx_q;

  assign rd_req = {bus.scan_read,  bus.gpu_read,  bus.cpu_read};
  assign wr_req = {bus.scan_write, bus.gpu_write, bus.cpu_write};
  assign req    = rd_req | wr_req;

  rr_pick3 u_pick (
    .req   (req),
    .last  (last),
    .grant (grant),
    .valid (valid)
  );

  assign win = onehot_idx(grant);

  always_comb begin
    sel_idx   = bus.cpu_idx;
    sel_wbyte = bus.cpu_wbyte;
    case (win)
      CLI_GPU:  begin sel_idx = bus.gpu_idx;  sel_wbyte = bus.gpu_wbyte;  end
      CLI_SCAN: begin sel_idx = bus.scan_idx; sel_wbyte = bus.scan_wbyte; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last        <= CLI_SCAN;
      gnt         <= CLI_CPU;
      ack_q       <= 3'b000;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      rd_byte_q   <= '0;
      rd_idx_q    <= '0;
      wr_idx_q    <= '0;
      wr_byte_q   <= '0;
    end else begin
      ack_q       <= 3'b000;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      case (state)
        IDLE: begin
          if (valid) begin
            last <= win;
            gnt  <= win;
            // Write wins over read when a client raises both.
            if (wr_req[win]) begin
              mem_write_q <= 1'b1;
              wr_idx_q    <= sel_idx;
              wr_byte_q   <= sel_wbyte;
              ack_q[win]  <= 1'b1;
              state       <= DONE;
            end else begin
              mem_read_q <= 1'b1;
              rd_idx_q   <= sel_idx;
              state      <= READ;
            end
          end
        end
        READ: begin
          if (bus.mem_read_ack) begin
            rd_byte_q  <= bus.mem_read_byte;
            ack_q[gnt] <= 1'b1;
            state      <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cpu_ack        = ack_q[0];
  assign bus.gpu_ack        = ack_q[1];
  assign bus.scan_ack       = ack_q[2];
  assign bus.rd_byte        = rd_byte_q;
  assign bus.mem_read       = mem_read_q;
  assign bus.mem_read_idx   = rd_idx_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.mem_write_idx  = wr_idx_q;
  assign bus.mem_write_byte = wr_byte_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural mem of programmable read latency.
module tb_mem_arbiter;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   lat   = 1;

  mem_arbiter_if #(.ADDR_W(12), .DATA_W(8)) bus ();

  mem_arbiter #(.ADDR_W(12), .DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: writes on strobe, read ack arrives lat cycles after the strobe.
  logic [7:0]  mem_data [0:4095];
  logic [11:0] ridx;
  int          cnt = 0;

  always @(posedge clk) begin
    bus.mem_read_ack <= 1'b0;
    if (reset) begin
      mem_data[12'h042] <= 8'hFF;
      mem_data[12'h005] <= 8'h5A;
    end
    if (bus.mem_write) mem_data[bus.mem_write_idx] <= bus.mem_write_byte;
    if (bus.mem_read) begin
      ridx <= bus.mem_read_idx;
      if (lat <= 1) begin
        bus.mem_read_ack  <= 1'b1;
        bus.mem_read_byte <= mem_data[bus.mem_read_idx];
      end else begin
        cnt <= lat - 1;
      end
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        bus.mem_read_ack  <= 1'b1;
        bus.mem_read_byte <= mem_data[ridx];
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] acks();
    return {bus.scan_ack, bus.gpu_ack, bus.cpu_ack};
  endfunction

  task automatic set_wr(input int c, input logic v);
    case (c)
      0:       bus.cpu_write  = v;
      1:       bus.gpu_write  = v;
      default: bus.scan_write = v;
    endcase
  endtask

  initial begin
    reset = 1'b1;
    bus.cpu_read = 0;  bus.gpu_read = 0;  bus.scan_read = 0;
    bus.cpu_write = 0; bus.gpu_write = 0; bus.scan_write = 0;
    bus.cpu_idx = 0;   bus.gpu_idx = 0;   bus.scan_idx = 0;
    bus.cpu_wbyte = 0; bus.gpu_wbyte = 0; bus.scan_wbyte = 0;
    tick(); tick();
    chk("rst_acks",      32'(acks()), 0);
    chk("rst_mem_read",  32'(bus.mem_read), 0);
    chk("rst_mem_write", 32'(bus.mem_write), 0);
    chk("rst_rd_byte",   32'(bus.rd_byte), 0);
    chk("rst_rd_idx",    32'(bus.mem_read_idx), 0);
    chk("rst_wr_idx",    32'(bus.mem_write_idx), 0);
    chk("rst_wr_byte",   32'(bus.mem_write_byte), 0);
    reset = 1'b0;

    // Single CPU write
    bus.cpu_write = 1; bus.cpu_idx = 12'h100; bus.cpu_wbyte = 8'hA5;
    tick();
    chk("wr_strobe",  32'(bus.mem_write), 1);
    chk("wr_idx",     32'(bus.mem_write_idx), 32'h100);
    chk("wr_byte",    32'(bus.mem_write_byte), 32'hA5);
    chk("wr_ack",     32'(acks()), 32'b001);
    chk("wr_no_read", 32'(bus.mem_read), 0);
    bus.cpu_write = 0;
    tick();
    chk("wr_done_strobe", 32'(bus.mem_write), 0);
    chk("wr_done_acks",   32'(acks()), 0);
    chk("wr_mem_data",    32'(mem_data[12'h100]), 32'hA5);
    chk("wr_idx_hold",    32'(bus.mem_write_idx), 32'h100);

    // GPU read, mem latency 1
    bus.gpu_read = 1; bus.gpu_idx = 12'h042;
    tick();
    chk("rd_strobe",  32'(bus.mem_read), 1);
    chk("rd_idx",     32'(bus.mem_read_idx), 32'h042);
    chk("rd_acks0",   32'(acks()), 0);
    tick();
    chk("rd_strobe1", 32'(bus.mem_read), 0);
    chk("rd_acks1",   32'(acks()), 0);
    tick();
    chk("rd_ack",     32'(acks()), 32'b010);
    chk("rd_byte",    32'(bus.rd_byte), 32'hFF);
    bus.gpu_read = 0;
    tick();
    chk("rd_done_acks",  32'(acks()), 0);
    chk("rd_byte_hold",  32'(bus.rd_byte), 32'hFF);
    chk("rd_idx_hold",   32'(bus.mem_read_idx), 32'h042);

    // Three simultaneous writers after reset, two rounds
    reset = 1'b1; tick(); reset = 1'b0;
    bus.cpu_idx = 12'h200; bus.cpu_wbyte = 8'h11;
    bus.gpu_idx = 12'h201; bus.gpu_wbyte = 8'h22;
    bus.scan_idx = 12'h202; bus.scan_wbyte = 8'h33;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 3; c++) set_wr(c, 1'b1);
      for (int c = 0; c < 3; c++) begin
        tick();
        chk($sformatf("rr%0d_ack%0d", r, c), 32'(acks()), 32'(1 << c));
        chk($sformatf("rr%0d_idx%0d", r, c), 32'(bus.mem_write_idx), 32'h200 + c);
        set_wr(c, 1'b0);
        tick();
        chk($sformatf("rr%0d_gap%0d", r, c), 32'(acks()), 0);
      end
    end
    chk("rr_mem_202", 32'(mem_data[12'h202]), 32'h33);

    // CPU hogs, GPU requests once
    bus.cpu_write = 1; bus.cpu_idx = 12'h210; bus.cpu_wbyte = 8'h44;
    bus.gpu_write = 1; bus.gpu_idx = 12'h211; bus.gpu_wbyte = 8'h55;
    tick();
    chk("hog_first", 32'(acks()), 32'b001);
    tick(); tick();
    chk("hog_gpu_second", 32'(acks()), 32'b010);
    chk("hog_gpu_idx",    32'(bus.mem_write_idx), 32'h211);
    bus.gpu_write = 0;
    tick(); tick();
    chk("hog_cpu_again", 32'(acks()), 32'b001);
    bus.cpu_write = 0;
    tick();

    // Reset during READ, late mem_read_ack must be ignored
    lat = 4;
    bus.cpu_read = 1; bus.cpu_idx = 12'h005;
    tick();
    chk("mid_strobe", 32'(bus.mem_read), 1);
    tick();
    chk("mid_wait", 32'(acks()), 0);
    reset = 1'b1; bus.cpu_read = 0;
    tick();
    chk("mid_rst_acks",    32'(acks()), 0);
    chk("mid_rst_read",    32'(bus.mem_read), 0);
    chk("mid_rst_rdbyte",  32'(bus.rd_byte), 0);
    chk("mid_rst_rdidx",   32'(bus.mem_read_idx), 0);
    chk("mid_rst_wridx",   32'(bus.mem_write_idx), 0);
    chk("mid_rst_wrbyte",  32'(bus.mem_write_byte), 0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("late_acks%0d", k),   32'(acks()), 0);
      chk($sformatf("late_rdbyte%0d", k), 32'(bus.rd_byte), 0);
      chk($sformatf("late_read%0d", k),   32'(bus.mem_read), 0);
    end
    lat = 1;
    bus.gpu_read = 1; bus.gpu_idx = 12'h042;
    tick();
    chk("post_strobe", 32'(bus.mem_read), 1);
    tick(); tick();
    chk("post_ack",  32'(acks()), 32'b010);
    chk("post_byte", 32'(bus.rd_byte), 32'hFF);
    bus.gpu_read = 0;
    tick();

    // Read and write raised together: write only
    bus.scan_read = 1; bus.scan_write = 1; bus.scan_idx = 12'h300; bus.scan_wbyte = 8'h3C;
    tick();
    chk("rw_write",   32'(bus.mem_write), 1);
    chk("rw_noread",  32'(bus.mem_read), 0);
    chk("rw_ack",     32'(acks()), 32'b100);
    chk("rw_idx",     32'(bus.mem_write_idx), 32'h300);
    chk("rw_byte",    32'(bus.mem_write_byte), 32'h3C);
    bus.scan_read = 0; bus.scan_write = 0;
    tick();
    chk("rw_acks_gap", 32'(acks()), 0);
    chk("rw_mem",      32'(mem_data[12'h300]), 32'h3C);
    tick();
    chk("rw_acks_idle", 32'(acks()), 0);
    chk("rw_noread2",   32'(bus.mem_read), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Three-client arbiter that shares the single-port CHIP-8 `mem` block between the CPU, the GPU sprite engine and the display scanout reader. Each client sees a private request/ack port with `mem`-style read/write semantics. The arbiter serialises transactions onto `mem`'s read and write ports using round-robin grant order. It sits between the clients and `mem0` in the top level, replacing the direct GPU/CPU-to-`mem` wiring.

## Interface
- `ADDR_W`, 12: memory index width.
- `DATA_W`, 8: memory byte width.

- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `cpu_read`, `gpu_read`, `scan_read`  in  1 each  read request level; held until the matching ack.
- `cpu_write`, `gpu_write`, `scan_write`  in  1 each  write request level; held until the matching ack.
- `cpu_idx`, `gpu_idx`, `scan_idx`  in  ADDR_W each  request address; stable while request held.
- `cpu_wbyte`, `gpu_wbyte`, `scan_wbyte`  in  DATA_W each  write data.
- `cpu_ack`, `gpu_ack`, `scan_ack`  out  1 each  one-cycle completion pulse.
- `rd_byte`  out  DATA_W  read data; valid while any ack of a read is high. Holds its value otherwise.
- `mem_read`  out  1  one-cycle read strobe to `mem`.
- `mem_read_idx`  out  ADDR_W  read address.
- `mem_read_byte`  in  DATA_W  read data from `mem`.
- `mem_read_ack`  in  1  `mem` read completion pulse; arrives 1 or more cycles after `mem_read`.
- `mem_write`  out  1  one-cycle write strobe to `mem`.
- `mem_write_idx`  out  ADDR_W  write address.
- `mem_write_byte`  out  DATA_W  write data.

## Operation
- FSM states: IDLE, READ, DONE.
- IDLE:
  - Pending clients are those with read or write high.
  - Pick a winner round-robin, starting after `last`, in order cpu→gpu→scan→cpu.
  - If a client asserts both read and write, the write is performed and the read is ignored.
  - Winner write: register `mem_write`=1 with its idx/wbyte, pulse its ack, set `last`=winner, go to DONE.
  - Winner read: register `mem_read`=1 with its idx, set `last`=winner, go to READ.
  - No pending client: stay in IDLE.
- READ:
  - `mem_read` is 0 after its single cycle.
  - On `mem_read_ack`: latch `mem_read_byte` into `rd_byte`, pulse the granted client's ack, go to DONE.
  - Wait indefinitely otherwise.
- DONE:
  - Strobes and acks return to 0; go to IDLE.
  - This cycle gives clients one edge to drop or change their request before re-arbitration.
- `mem_read_idx` and `mem_write_idx` hold their last value when not strobed.
- Only one transaction is outstanding at a time. `mem_read` and `mem_write` are never high together.
- Reset, including mid-READ:
  - State goes to IDLE and all strobes/acks go to 0.
  - `rd_byte`, `mem_read_idx`, `mem_write_idx` and `mem_write_byte` go to 0.
  - `last`=scan, so cpu has first priority.
  - A `mem_read_ack` arriving after reset is ignored.
- A `mem_read_ack` received outside READ is ignored.

## Timing
- Write: request sampled at edge E0 → `mem_write` and the ack are both high in cycle E0..E1 → DONE → IDLE samples again at E2. Throughput is one write per 2 cycles.
- Read with `mem` latency L (ack L cycles after strobe): strobe in cycle 1, ack to client in cycle L+1, DONE, re-arbitrate. Total L+2 cycles.
- Client ack is registered; no combinational path from any request to any output.
- Starvation bound: a pending client waits at most two other transactions.

## Structure
- Shared package `mem_arb_pkg` holds:
  - FSM state encoding (IDLE/READ/DONE).
  - Client index constants CLI_CPU=0, CLI_GPU=1, CLI_SCAN=2.
- One sub-module, `rr_pick3`:
  - Combinational 3-way round-robin picker.
  - Inputs: request vector, `last`. Outputs: one-hot grant, valid.
- Request muxing, FSM and output registers stay in `mem_arbiter`.

## Test plan
- Single CPU write, idx 'h100, byte 'hA5 → `mem_write` 1 cycle later with idx 'h100 and byte 'hA5; `cpu_ack` in the same cycle; `mem0.data['h100]`='hA5.
- GPU read of 'h42 (preloaded 'hFF), `mem` latency 1 → `gpu_ack` with `rd_byte`='hFF exactly 2 cycles after the request is sampled.
- All three clients request writes to 'h200/'h201/'h202 at once after reset:
  - Grant order is cpu, gpu, scan, with acks 2 cycles apart.
  - A repeated round resumes at cpu after scan.
- CPU holds continuous requests while GPU requests once → GPU is granted no later than the second arbitration.
- Reset asserted while in READ, then a late `mem_read_ack` arrives → no ack pulses, all outputs 0, and the next request is serviced normally.
- A client asserts read and write together at 'h300 with byte 'h3C → only `mem_write` is issued and one ack is pulsed.
